// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue
//   Instruction prefetch queue between instruction memory and the fetch stage.
//   Issues sequential word fetches ahead of the core, buffers returned words
//   with their PCs in a DEPTH-entry FIFO, and flushes on a redirect while
//   discarding responses that were already in flight when it happened.
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   imem_req_valid/ready/addr  fetch request channel (addr = fetch_pc)
//   imem_resp_valid/data       in-order responses, one per accepted request
//   redirect, redirect_pc      flush and restart fetching at redirect_pc
//   deq_valid/ready            head entry handshake toward the fetch stage
//   deq_instr, deq_pc          head instruction and its PC
//   count                      occupied FIFO entries
module inst_prefetch_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      INST_LEN = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [WIDTH-1:0]         imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [INST_LEN-1:0]      imem_resp_data,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [INST_LEN-1:0]      deq_instr,
    output logic [WIDTH-1:0]         deq_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [INST_LEN-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0]    pc_mem    [DEPTH];
    logic [WIDTH-1:0]    pend_mem  [DEPTH];

    logic [WIDTH-1:0] fetch_pc;
    logic [AW-1:0]    wr_ptr, rd_ptr, pend_wr, pend_rd;
    logic [CW-1:0]    count_q, outstanding, drop;

    logic [CW:0] occupancy;
    logic        req_fire, resp_fire, resp_keep, deq_fire;

    always_comb begin
        // Entries held plus requests in flight; keeping this <= DEPTH means
        // every response always has a FIFO slot waiting for it.
        occupancy      = {1'b0, count_q} + {1'b0, outstanding};
        imem_req_valid = reset & ~redirect & (occupancy < DEPTH_W);
        imem_req_addr  = fetch_pc;
        deq_valid      = reset & ~redirect & (count_q != '0);
        deq_instr      = instr_mem[rd_ptr];
        deq_pc         = pc_mem[rd_ptr];
        count          = count_q;
        req_fire       = imem_req_valid & imem_req_ready;
        resp_fire      = reset & imem_resp_valid;
        // A response arriving in a redirect cycle belongs to the old stream.
        resp_keep      = resp_fire & (drop == '0) & ~redirect;
        deq_fire       = deq_valid & deq_ready;
    end

    // Storage arrays carry no reset; validity comes from the counters.
    always_ff @(posedge clk) begin
        if (resp_keep) begin
            instr_mem[wr_ptr] <= imem_resp_data;
            pc_mem[wr_ptr]    <= pend_mem[pend_rd];
        end
        if (req_fire) begin
            pend_mem[pend_wr] <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            count_q     <= '0;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pend_wr     <= '0;
            pend_rd     <= '0;
        end else begin
            // The pending-address FIFO tracks the memory, not the redirect:
            // every accepted request gets exactly one response to pop it.
            if (req_fire) begin
                fetch_pc <= fetch_pc + WIDTH'(4);
                pend_wr  <= pend_wr + AW'(1);
            end
            if (resp_fire) begin
                pend_rd <= pend_rd + AW'(1);
            end
            case ({req_fire, resp_fire})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase

            if (redirect) begin
                fetch_pc <= redirect_pc;
                count_q  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                // No request is issued here, so everything still in flight
                // after this cycle's response belongs to the old stream.
                drop     <= outstanding - CW'(resp_fire);
            end else begin
                if (resp_fire && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (resp_keep) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (deq_fire) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({resp_keep, deq_fire})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // A response with nothing outstanding means the memory broke protocol.
    a_resp_has_request: assert property (
        @(posedge clk) disable iff (!reset) imem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [2:0]  count;

    always #5 clk = ~clk;

    inst_prefetch_queue #(
        .WIDTH   (32),
        .INST_LEN(32),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_instr      (deq_instr),
        .deq_pc         (deq_pc),
        .count          (count)
    );

    int total = 0;
    int bad   = 0;

    // Memory model: in-order queue of accepted addresses with a due cycle.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;
    mreq_t       memq[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;

    // Scoreboard: the dequeue stream must be sequential from the last redirect.
    logic [31:0] exp_pc = '0;
    int          deq_cnt = 0;

    logic        rf, df;
    logic [31:0] ra;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First half of a cycle, entered at negedge with TB inputs already set.
    task automatic pre();
        int occ;
        if (reset && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(memq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        rf = imem_req_valid & imem_req_ready;
        ra = imem_req_addr;
        df = deq_valid & deq_ready;
        if (reset) begin
            occ = int'(count) + memq.size();
            check("credit_bound", 32'(occ <= DEPTH), 32'd1);
        end
        if (df) begin
            check("deq_pc", deq_pc, exp_pc);
            check("deq_instr", deq_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            deq_cnt++;
        end
        if (redirect && reset) exp_pc = redirect_pc;
    endtask

    task automatic post();
        @(posedge clk);
        cyc++;
        if (imem_resp_valid) void'(memq.pop_front());
        if (rf) memq.push_back('{ra, cyc + lat - 1});
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        redirect = 1'b0;
        deq_ready = 1'b0;
        imem_req_ready = 1'b0;
        memq.delete();
        for (int i = 0; i < n; i++) begin
            pre();
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_deq_valid", 32'(deq_valid), 32'd0);
            post();
            check("rst_count", 32'(count), 32'd0);
        end
        reset = 1'b1;
        exp_pc = '0;
    endtask

    typedef struct {
        logic        rr;
        logic        dr;
        logic        rd;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] ea;
        logic        edv;
        logic [31:0] epc;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          hit;
        logic [31:0] rnd;

        // Reset release, 1-cycle memory: fill to DEPTH, one deq refills one
        // slot, then redirect near the top of the address space.
        //            rr  dr  rd  rpc            ev  ea             edv epc            cnt
        vecs[0]  = '{1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0,          0};
        vecs[1]  = '{1, 0, 0, 32'h0,          1, 32'h4,          0, 32'h0,          0};
        vecs[2]  = '{1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0,          1};
        vecs[3]  = '{1, 0, 0, 32'h0,          1, 32'hC,          1, 32'h0,          2};
        vecs[4]  = '{1, 0, 0, 32'h0,          0, 32'h10,         1, 32'h0,          3};
        vecs[5]  = '{1, 0, 0, 32'h0,          0, 32'h10,         1, 32'h0,          4};
        vecs[6]  = '{1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h0,          4};
        vecs[7]  = '{1, 0, 0, 32'h0,          1, 32'h10,         1, 32'h4,          3};
        vecs[8]  = '{1, 0, 0, 32'h0,          0, 32'h14,         1, 32'h4,          3};
        vecs[9]  = '{1, 0, 0, 32'h0,          0, 32'h14,         1, 32'h4,          4};
        vecs[10] = '{1, 1, 1, 32'hFFFF_FFFC,  0, 32'h14,         0, 32'h0,          4};
        vecs[11] = '{1, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0,          0};
        vecs[12] = '{1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          0};
        vecs[13] = '{1, 1, 0, 32'h0,          1, 32'h4,          1, 32'hFFFF_FFFC,  1};
        vecs[14] = '{1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0,          1};

        @(negedge clk);
        do_reset(3);
        lat = 1;

        for (int i = 0; i < 15; i++) begin
            imem_req_ready = vecs[i].rr;
            deq_ready      = vecs[i].dr;
            redirect       = vecs[i].rd;
            redirect_pc    = vecs[i].rpc;
            pre();
            check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].ea);
            check($sformatf("v%0d_deq_valid", i), 32'(deq_valid), 32'(vecs[i].edv));
            if (vecs[i].edv) check($sformatf("v%0d_deq_pc", i), deq_pc, vecs[i].epc);
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
            post();
        end
        redirect = 1'b0;

        // Redirect together with a response and deq_ready: both suppressed.
        redirect = 1'b1;
        redirect_pc = 32'h200;
        deq_ready = 1'b1;
        pre();
        check("r4_resp_present", 32'(imem_resp_valid), 32'd1);
        check("r4_deq_valid", 32'(deq_valid), 32'd0);
        check("r4_req_valid", 32'(imem_req_valid), 32'd0);
        post();
        redirect = 1'b0;
        check("r4_count_after", 32'(count), 32'd0);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            pre();
            if (deq_valid) begin
                check("r4_first_pc", deq_pc, 32'h200);
                hit = 1'b1;
            end
            post();
        end
        if (!hit) check("r4_first_deq_timeout", 32'd0, 32'd1);

        // 3-cycle memory, redirect while three requests are in flight.
        do_reset(2);
        lat = 3;
        imem_req_ready = 1'b1;
        deq_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (memq.size() == 3) begin
                redirect = 1'b1;
                redirect_pc = 32'h100;
                hit = 1'b1;
            end
            pre();
            post();
            redirect = 1'b0;
        end
        if (!hit) check("r3_inflight_timeout", 32'd0, 32'd1);
        check("r3_count_after", 32'(count), 32'd0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            pre();
            if (deq_valid) begin
                check("r3_first_pc", deq_pc, 32'h100);
                check("r3_first_instr", deq_instr, mem_word(32'h100));
                hit = 1'b1;
            end
            post();
        end
        if (!hit) check("r3_first_deq_timeout", 32'd0, 32'd1);

        // Random traffic with a mid-run reset; scoreboard checks every dequeue.
        do_reset(2);
        deq_cnt = 0;
        for (int seg = 0; seg < 2; seg++) begin
            for (int i = 0; i < 1500; i++) begin
                imem_req_ready = ($urandom_range(0, 3) != 0);
                deq_ready      = ($urandom_range(0, 2) != 0);
                redirect       = ($urandom_range(0, 39) == 0);
                rnd            = $urandom;
                redirect_pc    = {rnd[31:2], 2'b00};
                lat            = $urandom_range(1, 4);
                pre();
                post();
            end
            redirect = 1'b0;
            if (seg == 0) do_reset(2);
        end
        check("rand_progress", 32'(deq_cnt > 500), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
